// File: rtl/stream_mux.sv
// stream_mux: N-channel valid/ready stream multiplexer with a registered
// output stage. Grants either an explicitly selected channel or rotates
// round-robin, and counts completed output transfers.
module stream_mux #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  input  logic                 out_ready,
  output logic [15:0]          xfer_cnt
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_ch;
  logic [15:0]      r_xfer_cnt;
  logic [SELW-1:0]  r_last_grant;

  logic             w_load;
  logic             w_rr_hit;
  logic [SELW-1:0]  w_rr_gnt;
  logic [SELW-1:0]  w_rr_idx;
  logic             w_gnt_valid;
  logic [SELW-1:0]  w_gnt;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [WIDTH-1:0] w_gnt_data;
  logic [NCH-1:0]   w_in_ready;

  // The output register can take a new word when it is empty or being drained.
  assign w_load     = !r_out_valid || out_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  // Round-robin search: first valid channel starting one past the last grant.
  // NCH is a power of two, so index arithmetic wraps naturally in SELW bits.
  always_comb begin
    w_rr_hit = 1'b0;
    w_rr_gnt = '0;
    w_rr_idx = '0;
    for (int k = 1; k <= NCH; k++) begin
      w_rr_idx = r_last_grant + SELW'(k);
      if (!w_rr_hit && in_valid[w_rr_idx]) begin
        w_rr_hit = 1'b1;
        w_rr_gnt = w_rr_idx;
      end
    end
  end

  // Explicit select grants only the chosen channel, never a fallback.
  assign w_gnt_valid = mode ? w_rr_hit : in_valid[sel];
  assign w_gnt       = mode ? w_rr_gnt : sel;
  assign w_in_xfer   = w_load && w_gnt_valid;

  // Only the granted channel sees ready, and only while the output can load.
  always_comb begin
    w_in_ready = '0;
    if (rst_n && w_in_xfer) begin
      w_in_ready[w_gnt] = 1'b1;
    end
  end

  assign in_ready = w_in_ready;

  // Pick the granted channel's word out of the packed input bus.
  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (SELW'(i) == w_gnt) begin
        w_gnt_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output stage: load on grant, empty on an idle load, hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
    end else if (w_load) begin
      r_out_valid <= w_gnt_valid;
      if (w_gnt_valid) begin
        r_out_data <= w_gnt_data;
        r_out_ch   <= w_gnt;
      end
    end
  end

  // Round-robin pointer; reset to the top channel so channel 0 goes first,
  // and only moved by round-robin transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= SELW'(NCH-1);
    end else if (mode && w_in_xfer) begin
      r_last_grant <= w_gnt;
    end
  end

  // Completed output transfer counter, free-running with natural wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_cnt <= '0;
    end else if (w_out_xfer) begin
      r_xfer_cnt <= r_xfer_cnt + 16'd1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign xfer_cnt  = r_xfer_cnt;

endmodule

// File: tb/tb_stream_mux.sv
// tb_stream_mux: table-driven vectors plus hand sequences for stream_mux,
// with a scoreboard queue holding the words expected at the output.
module tb_stream_mux;

  localparam int WIDTH = 16;
  localparam int NCH   = 4;
  localparam int SELW  = 2;

  logic                 clk;
  logic                 rst_n;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [NCH-1:0]       in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_ready;
  logic [15:0]          xfer_cnt;

  stream_mux #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt)
  );

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] iv;
    logic       outRdy;
    logic [3:0] expIr;
  } vec_t;

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] data;
  } sbItem_t;

  sbItem_t sbQ[$];
  vec_t    vecs[25];
  int      nTests = 0;
  int      nFail = 0;
  int      stepCount = 0;
  logic [15:0] expCnt = 16'd0;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] chData(input int ch, input int step);
    return {ch[3:0], 4'hA, step[7:0]};
  endfunction

  function automatic int ohIdx(input logic [3:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Compare outputs against the scoreboard, then retire/push words for this cycle.
  task automatic checkOutput(input logic orr, input logic [3:0] expIr, input string tag);
    sbItem_t it;
    check($sformatf("%s.out_valid", tag), {31'd0, out_valid}, {31'd0, sbQ.size() != 0});
    if (sbQ.size() != 0) begin
      check($sformatf("%s.out_ch", tag), {30'd0, out_ch}, {30'd0, sbQ[0].ch});
      check($sformatf("%s.out_data", tag), {16'd0, out_data}, {16'd0, sbQ[0].data});
    end
    check($sformatf("%s.xfer_cnt", tag), {16'd0, xfer_cnt}, {16'd0, expCnt});
    check($sformatf("%s.in_ready", tag), {28'd0, in_ready}, {28'd0, expIr});
    if (sbQ.size() != 0 && orr) begin
      sbQ.delete(0);
      expCnt = expCnt + 16'd1;
    end
    if (expIr != 4'b0000) begin
      it.ch   = 2'(ohIdx(expIr));
      it.data = chData(ohIdx(expIr), stepCount);
      sbQ.push_back(it);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and check before the next rise.
  task automatic applyStimulus(input logic m, input logic [1:0] s, input logic [3:0] iv,
                               input logic orr, input logic [3:0] expIr, input string tag);
    mode      = m;
    sel       = s;
    in_valid  = iv;
    out_ready = orr;
    for (int c = 0; c < NCH; c++) in_data[c*WIDTH +: WIDTH] = chData(c, stepCount);
    #1;
    checkOutput(orr, expIr, tag);
    stepCount++;
    @(negedge clk);
  endtask

  initial begin
    bit hit;
    // mode, sel, in_valid, out_ready, expected in_ready
    vecs[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100};
    vecs[1]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100};
    vecs[2]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100};
    vecs[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001};
    vecs[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010};
    vecs[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100};
    vecs[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000};
    vecs[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001};
    vecs[8]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010};
    vecs[9]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000};
    vecs[10] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010};
    vecs[11] = '{1'b0, 2'd1, 4'b1101, 1'b1, 4'b0000};
    vecs[12] = '{1'b1, 2'd1, 4'b1101, 1'b1, 4'b0100};
    vecs[13] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000};
    vecs[14] = '{1'b0, 2'd1, 4'b0010, 1'b1, 4'b0010};
    vecs[15] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001};
    vecs[16] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000};
    vecs[17] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000};
    vecs[18] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010};
    vecs[19] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000};
    vecs[20] = '{1'b1, 2'd0, 4'b0000, 1'b0, 4'b0000};
    vecs[21] = '{1'b0, 2'd0, 4'b0001, 1'b0, 4'b0001};
    vecs[22] = '{1'b0, 2'd0, 4'b0001, 1'b0, 4'b0000};
    vecs[23] = '{1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001};
    vecs[24] = '{1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000};

    rst_n     = 1'b0;
    mode      = 1'b1;
    sel       = 2'd0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    in_data   = {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    #12;
    check("reset.in_ready", {28'd0, in_ready}, 32'd0);
    check("reset.out_valid", {31'd0, out_valid}, 32'd0);
    check("reset.out_data", {16'd0, out_data}, 32'd0);
    check("reset.out_ch", {30'd0, out_ch}, 32'd0);
    check("reset.xfer_cnt", {16'd0, xfer_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      applyStimulus(vecs[i].mode, vecs[i].sel, vecs[i].iv, vecs[i].outRdy,
                    vecs[i].expIr, $sformatf("vec%0d", i));
    end

    // Long backpressure: word held for five cycles while inputs keep changing.
    applyStimulus(1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000, "bp.load");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, $sformatf("bp.hold%0d", i));
    applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, "bp.release");
    applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, "bp.drain");

    // Reset while a word is held discards it; round-robin restarts at channel 0.
    applyStimulus(1'b0, 2'd2, 4'b0100, 1'b0, 4'b0100, "mid.load");
    #2;
    rst_n = 1'b0;
    #1;
    check("mid.out_valid", {31'd0, out_valid}, 32'd0);
    check("mid.out_data", {16'd0, out_data}, 32'd0);
    check("mid.xfer_cnt", {16'd0, xfer_cnt}, 32'd0);
    check("mid.in_ready", {28'd0, in_ready}, 32'd0);
    sbQ.delete();
    expCnt = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, "mid.first");
    applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, "mid.second");

    // Stream continuously until the counter reaches its top value.
    mode      = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    hit = 1'b0;
    for (int n = 0; n < 70000 && !hit; n++) begin
      @(negedge clk);
      if (xfer_cnt == 16'hFFFF) hit = 1'b1;
    end
    check("wrap.reach", {31'd0, hit}, 32'd1);
    check("wrap.out_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    check("wrap.xfer_cnt", {16'd0, xfer_cnt}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("wrst.out_valid", {31'd0, out_valid}, 32'd0);
    check("wrst.out_data", {16'd0, out_data}, 32'd0);
    check("wrst.out_ch", {30'd0, out_ch}, 32'd0);
    check("wrst.xfer_cnt", {16'd0, xfer_cnt}, 32'd0);
    check("wrst.in_ready", {28'd0, in_ready}, 32'd0);
    sbQ.delete();
    expCnt = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, "wrst.first");
    applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, "wrst.drain");

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
